// File: rtl/gray_rr_demux_pkg.sv
// Shared types and helpers for the round-robin Gray-select pulse demultiplexer.
package nusadc_demux_pkg;

  localparam int unsigned MAX_SEL_W = 5;

  typedef logic [MAX_SEL_W-1:0] code_t;

  function automatic int unsigned ch_count(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

  function automatic code_t bin2gray(input code_t b);
    return b ^ (b >> 1);
  endfunction

  // Binary is the XOR of every right-shift of the Gray code.
  function automatic code_t gray2bin(input code_t g);
    code_t b;
    b = g;
    for (int unsigned s = 1; s < MAX_SEL_W; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_rr_demux_if.sv
// Pulse, mask, load and status bundle between the strobe source and the demux.
import nusadc_demux_pkg::*;

interface gray_rr_demux_if #(
  parameter int unsigned SEL_W = 3
);
  localparam int unsigned CH = ch_count(SEL_W);

  logic             i;
  logic             en;
  logic [CH-1:0]    ch_mask;
  logic             load;
  logic [SEL_W-1:0] load_idx;
  logic [CH-1:0]    i_demuxed;
  logic [SEL_W-1:0] sel;
  logic             wrap;
  logic             err_nomask;

  modport master (
    output i, en, ch_mask, load, load_idx,
    input  i_demuxed, sel, wrap, err_nomask
  );

  modport slave (
    input  i, en, ch_mask, load, load_idx,
    output i_demuxed, sel, wrap, err_nomask
  );
endinterface

// File: rtl/gray_rr_demux_rr_next_enabled.sv
// Rotating priority search: first set mask bit at or after start, modulo CH.
module rr_next_enabled #(
  parameter int unsigned CH = 8
) (
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] start,
  input  logic [CH-1:0]                          mask,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] hit_idx,
  output logic                                   found
);
  localparam int unsigned W = (CH > 1) ? $clog2(CH) : 1;

  logic [W-1:0] k;

  // CH is a power of two, so W-bit addition wraps exactly at CH.
  always_comb begin
    hit_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int unsigned off = 0; off < CH; off++) begin
      k = start + W'(off);
      if (!found && mask[k]) begin
        hit_idx = k;
        found   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/gray_rr_demux.sv
// Round-robin pulse demux: steers each accepted pulse to the current enabled channel, then advances.
import nusadc_demux_pkg::*;

module gray_rr_demux #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned RST_IDX = 0
) (
  input  logic            clk,
  input  logic            rst,
  gray_rr_demux_if.slave  bus
);
  localparam int unsigned CH = ch_count(SEL_W);

  logic [SEL_W-1:0] idx, idx_d, tgt, nxt, nxt_start, sel_q;
  logic [CH-1:0]    demux_q;
  logic             found, nxt_found, accept, wrap_q, err_q;

  rr_next_enabled #(.CH(CH)) u_tgt (
    .start   (idx),
    .mask    (bus.ch_mask),
    .hit_idx (tgt),
    .found   (found)
  );

  assign nxt_start = tgt + SEL_W'(1);

  // Searching from tgt+1 wraps back to tgt itself when only one channel is enabled.
  rr_next_enabled #(.CH(CH)) u_nxt (
    .start   (nxt_start),
    .mask    (bus.ch_mask),
    .hit_idx (nxt),
    .found   (nxt_found)
  );

  always_comb begin
    accept = bus.i && bus.en && found;
    idx_d  = idx;
    if (bus.load) begin
      idx_d = bus.load_idx;
    end else if (accept && nxt_found) begin
      idx_d = nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= SEL_W'(RST_IDX);
      sel_q   <= SEL_W'(bin2gray(code_t'(RST_IDX)));
      demux_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      idx     <= idx_d;
      sel_q   <= SEL_W'(bin2gray(code_t'(idx_d)));
      demux_q <= accept ? (CH'(1) << tgt) : '0;
      wrap_q  <= accept && !bus.load && (nxt <= tgt);
      err_q   <= bus.i && bus.en && !found;
    end
  end

  assign bus.i_demuxed  = demux_q;
  assign bus.sel        = sel_q;
  assign bus.wrap       = wrap_q;
  assign bus.err_nomask = err_q;
endmodule
